// File: rtl/ysyx_22050612_mem_responder.sv
// ysyx_22050612_mem_responder
// Memory-side end of the LSU load/store request channel. Holds a DEPTH x 64-bit
// RAM mapped at byte address BASE, serves one request at a time over a
// valid/ready request channel and answers after LATENCY cycles over a
// valid/ready response channel.
// Optional build macro: MEM_RESPONDER_RANDLAT_EN adds 0..3 pseudo-random extra
// wait cycles per request from an 8-bit LFSR seeded with 8'hA5.
module ysyx_22050612_mem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [63:0] DEPTH64 = 64'(DEPTH);
    localparam logic [4:0]  LAT_M1  = 5'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [4:0]  extra;

    logic        wen_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;

    logic [63:0] mem [0:DEPTH-1];

    logic        accept;
    logic        finish;
    logic [63:0] off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        commit_wr;

    // An accept is only possible in IDLE because req_ready mirrors that state.
    assign accept    = req_valid & req_ready;
    assign finish    = (state == WAIT) && (cnt == 5'd0);
    // Unsigned wrap makes addresses below BASE land far above DEPTH words,
    // so a single compare covers both ends of the window.
    assign off       = addr_q - BASE;
    assign in_range  = (off >> 3) < DEPTH64;
    assign idx       = off[AW+2:3];
    assign commit_wr = finish & wen_q & in_range;

`ifdef MEM_RESPONDER_RANDLAT_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR (taps 8,6,5,4) stepped once per accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Extra wait cycles come from the LFSR value before it advances.
    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    // Request fields are captured on accept; they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    // RAM write port: byte-lane merge at the WAIT->RESP edge, never reset.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            cnt        <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        cnt       <= LAT_M1 + extra;
                    end
                end
                WAIT: begin
                    if (cnt == 5'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= ~in_range;
                        resp_rdata <= (!wen_q && in_range) ? mem[idx] : 64'd0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 64'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_mem_responder.sv
// Directed bench for ysyx_22050612_mem_responder with LATENCY=4.
module tb_ysyx_22050612_mem_responder;

    localparam int          LAT   = 4;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_lfsr;
    logic [63:0] rd;
    logic        er;
    int          lt;

    ysyx_22050612_mem_responder #(
        .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference latency for the next accept; steps the LFSR model when enabled.
    function automatic int next_lat();
        int d;
`ifdef MEM_RESPONDER_RANDLAT_EN
        d = LAT + int'(m_lfsr[1:0]);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
        d = LAT;
`endif
        return d;
    endfunction

    // One complete transaction: accept, measure latency, handshake, check return to idle.
    task automatic txn(input string tag, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask,
                       output logic [63:0] rdata, output logic err);
        int lat;
        int exp_lat;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wdata; req_wmask = wmask; resp_ready = 1'b0;
        @(posedge clk);
        exp_lat = next_lat();
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_wmask = 8'h00; resp_ready = 1'b0;
        m_lfsr = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;

        // Known content in word 2, then a write to it aborted by reset in WAIT.
        txn("w2_init", 1'b1, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, rd, er);
        chk("w2_init_err", 64'(er), 64'd0);
        chk("w2_init_rdata", rd, 64'd0);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0010;
        req_wdata = 64'd0; req_wmask = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_wait_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_resp_rdata", resp_rdata, 64'd0);
        chk("abort_resp_err", 64'(resp_err), 64'd0);
        m_lfsr = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First accepts after reset also exercise the latency sequence.
        txn("abort_rd", 1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er);
        chk("abort_rd_rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
        chk("abort_rd_err", 64'(er), 64'd0);

        // Full write then read back.
        txn("w1_full", 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, rd, er);
        chk("w1_full_rdata", rd, 64'd0);
        chk("w1_full_err", 64'(er), 64'd0);
        txn("r1_full", 1'b0, 64'h8000_000D, 64'd0, 8'h00, rd, er);
        chk("r1_full_rdata", rd, 64'h1122_3344_5566_7788);
        chk("r1_full_err", 64'(er), 64'd0);

        // Partial write merges only the low four lanes.
        txn("w1_part", 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F, rd, er);
        txn("r1_part", 1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er);
        chk("r1_part_rdata", rd, 64'h1122_3344_AAAA_AAAA);

        // Zero-mask write is legal and changes nothing.
        txn("w1_mask0", 1'b1, 64'h8000_0008, 64'h0, 8'h00, rd, er);
        chk("w1_mask0_err", 64'(er), 64'd0);
        txn("r1_mask0", 1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er);
        chk("r1_mask0_rdata", rd, 64'h1122_3344_AAAA_AAAA);

        // Range boundaries: first and last words in range, neighbours outside.
        txn("w0", 1'b1, BASE, 64'h5555_6666_7777_8888, 8'hFF, rd, er);
        txn("wlast", 1'b1, 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er);
        chk("wlast_err", 64'(er), 64'd0);
        txn("r_below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, rd, er);
        chk("r_below_err", 64'(er), 64'd1);
        chk("r_below_rdata", rd, 64'd0);
        txn("r_above", 1'b0, 64'h8000_2000, 64'd0, 8'h00, rd, er);
        chk("r_above_err", 64'(er), 64'd1);
        chk("r_above_rdata", rd, 64'd0);
        txn("w_above", 1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
        chk("w_above_err", 64'(er), 64'd1);
        chk("w_above_rdata", rd, 64'd0);
        txn("w_below", 1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
        chk("w_below_err", 64'(er), 64'd1);
        txn("rlast", 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, rd, er);
        chk("rlast_rdata", rd, 64'h0123_4567_89AB_CDEF);
        chk("rlast_err", 64'(er), 64'd0);
        txn("r0", 1'b0, BASE, 64'd0, 8'h00, rd, er);
        chk("r0_rdata", rd, 64'h5555_6666_7777_8888);

        // Response back-pressure with a competing request held on the channel.
        begin
            int exp_lat;
            int lat;
            @(negedge clk);
            req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0008;
            req_wdata = 64'd0; req_wmask = 8'h00; resp_ready = 1'b0;
            @(posedge clk);
            exp_lat = next_lat();
            @(negedge clk);
            req_wen = 1'b1; req_wdata = 64'hBAD0_BAD0_BAD0_BAD0; req_wmask = 8'hFF;
            lat = 0;
            while (!resp_valid && lat < 40) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk("hold_latency", 64'(lat), 64'(exp_lat));
            for (int i = 0; i < 5; i++) begin
                chk("hold_valid", 64'(resp_valid), 64'd1);
                chk("hold_rdata", resp_rdata, 64'h1122_3344_AAAA_AAAA);
                chk("hold_req_ready", 64'(req_ready), 64'd0);
                @(posedge clk);
                @(negedge clk);
            end
            req_valid = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            chk("hold_release_valid", 64'(resp_valid), 64'd0);
            chk("hold_release_ready", 64'(req_ready), 64'd1);
        end
        txn("r1_after_hold", 1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er);
        chk("r1_after_hold_rdata", rd, 64'h1122_3344_AAAA_AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
